// File: rtl/pos_ctrl_pkg.sv
// Shared types for the position cell access controller: FSM states, read tag, read latency.
package pos_ctrl_pkg;

  localparam int unsigned POS_RD_LAT = 2;
  // Tag index width; must match the controller's ADDR_WIDTH.
  localparam int unsigned POS_IDX_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StWaitCnt,
    StStream,
    StDrain
  } pos_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 is_cnt;
    logic [POS_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/pos_rd_tag_pipe.sv
// Latency-matching shift register: a tag pushed with a memory read emerges as that read's data
// appears on mem_q.
module pos_rd_tag_pipe
  import pos_ctrl_pkg::*;
#(
  parameter int unsigned Depth = POS_RD_LAT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    busy
);

  rd_tag_t stage_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) busy = busy | stage_q[i].valid;
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// Read sequencer and write arbiter in front of one single-port position cell memory.
// Optional macro POS_CTRL_PERF_CNT_EN adds the perf_stall_cnt output.
module pos_cell_access_ctrl
  import pos_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned WR_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  input  logic                  rd_stall,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] rd_cnt,
  output logic                  cnt_err,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
`ifdef POS_CTRL_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned BurstW = $clog2(WR_BURST_MAX + 1);
  localparam int unsigned DrainW = $clog2(POS_RD_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] CntMax = ADDR_WIDTH'(PARTICLE_NUM - 1);

  pos_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rd_cnt_q;
  logic                  cnt_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BurstW-1:0]     burst_q;
  logic [DrainW-1:0]     drain_q;
  logic                  ready_en_q;

  logic                  rd_slot, rd_pend, burst_full, wr_fire, rd_grant, start_acc;
  logic                  cnt_ret, cnt_over, last_issue, drain_full, pipe_busy;
  logic [ADDR_WIDTH-1:0] rd_addr, cnt_raw, cnt_clamp;
  rd_tag_t               tag_in, tag_out;

  // Arbitration: writes win unless the burst budget is spent while a read slot is waiting.
  always_comb begin
    rd_slot    = (state_q == StRdCnt) || (state_q == StStream);
    rd_pend    = rd_slot && !rd_stall;
    burst_full = (burst_q == BurstW'(WR_BURST_MAX));
    // ready_en_q keeps wr_ready low while in reset.
    wr_ready   = ready_en_q && !(burst_full && rd_pend);
    wr_fire    = wr_valid && wr_ready;
    rd_grant   = rd_pend && !wr_fire;
    start_acc  = (state_q == StIdle) && rd_start;
    rd_addr    = (state_q == StStream) ? addr_q : '0;
    last_issue = rd_grant && (state_q == StStream) && (addr_q == rd_cnt_q);
    drain_full = (drain_q == DrainW'(POS_RD_LAT));

    tag_in = '0;
    if (rd_grant) begin
      tag_in.valid  = 1'b1;
      tag_in.is_cnt = (state_q == StRdCnt);
      tag_in.idx    = POS_IDX_W'(rd_addr);
    end

    cnt_ret   = tag_out.valid && tag_out.is_cnt;
    cnt_raw   = mem_q[ADDR_WIDTH-1:0];
    cnt_over  = (cnt_raw > CntMax);
    cnt_clamp = cnt_over ? CntMax : cnt_raw;
  end

  pos_rd_tag_pipe #(
    .Depth(POS_RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == StIdle),
    .tag_in (tag_in),
    .tag_out(tag_out),
    .busy   (pipe_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rd_start) state_d = StRdCnt;
      StRdCnt:   if (rd_grant) state_d = StWaitCnt;
      StWaitCnt: if (cnt_ret) state_d = (cnt_clamp == '0) ? StDrain : StStream;
      StStream:  if (last_issue) state_d = StDrain;
      StDrain:   if (rd_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // DRAIN always lasts the full read latency so done timing does not depend on the count.
  always_comb begin
    rd_busy = (state_q != StIdle);
    rd_done = (state_q == StDrain) && drain_full && !pipe_busy;
  end

  always_comb begin
    mem_rden    = rd_grant;
    mem_wren    = wr_fire;
    mem_address = wr_fire ? wr_addr : (rd_grant ? rd_addr : '0);
    mem_data    = wr_fire ? wr_data : '0;
    rd_valid    = tag_out.valid && !tag_out.is_cnt;
    rd_idx      = rd_valid ? ADDR_WIDTH'(tag_out.idx) : '0;
    rd_data     = rd_valid ? mem_q : '0;
    rd_cnt      = rd_cnt_q;
    cnt_err     = cnt_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q   <= '0;
      cnt_err_q  <= 1'b0;
      addr_q     <= '0;
      burst_q    <= '0;
      drain_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;

      if (start_acc) begin
        rd_cnt_q  <= '0;
        cnt_err_q <= 1'b0;
      end else if ((state_q == StWaitCnt) && cnt_ret) begin
        rd_cnt_q  <= cnt_clamp;
        cnt_err_q <= cnt_err_q | cnt_over;
      end

      if (state_q == StWaitCnt)                addr_q <= ADDR_WIDTH'(1);
      else if ((state_q == StStream) && rd_grant) addr_q <= addr_q + ADDR_WIDTH'(1);

      if (rd_grant || !rd_pend) burst_q <= '0;
      else if (wr_fire)         burst_q <= burst_q + BurstW'(1);

      if (state_q != StDrain) drain_q <= '0;
      else if (!drain_full)   drain_q <= drain_q + DrainW'(1);
    end
  end

`ifdef POS_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      perf_q <= '0;
    else if (start_acc)                              perf_q <= '0;
    else if (rd_slot && !rd_grant && (perf_q != '1)) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Scoreboard bench for pos_cell_access_ctrl with a behavioural 2-cycle-latency cell memory.
module tb_pos_cell_access_ctrl;

  localparam int DW = 96;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_start, rd_stall, rd_busy, rd_valid, rd_done, cnt_err;
  logic [DW-1:0] rd_data, wr_data, mem_data, mem_q;
  logic [AW-1:0] rd_idx, rd_cnt, wr_addr, mem_address;
  logic          wr_valid, wr_ready, mem_rden, mem_wren;
`ifdef POS_CTRL_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pos_cell_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_start   (rd_start),
    .rd_stall   (rd_stall),
    .rd_busy    (rd_busy),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_idx     (rd_idx),
    .rd_done    (rd_done),
    .rd_cnt     (rd_cnt),
    .cnt_err    (cnt_err),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
`ifdef POS_CTRL_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .mem_q      (mem_q)
  );

  function automatic logic [DW-1:0] pat(int i);
    return {32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i), 32'hF000_0000 | 32'(i)};
  endfunction

  function automatic logic [AW-1:0] waddr(int j);
    return (j == 7) ? 8'd0 : 8'(100 + j);
  endfunction

  function automatic logic [DW-1:0] wdata(int j);
    return {32'hC0DE_0000 + 32'(j), 32'h0, 32'(j)};
  endfunction

  // Cell memory model: bulk load, write, and read data two cycles after mem_rden.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q1, init_cnt;
  logic          init_req;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? init_cnt : pat(i);
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data;
    end
    if (mem_rden) q1 <= mem[mem_address];
    mem_q <= q1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            done;
    int            idx;
    logic [DW-1:0] data;
  } ev_t;

  ev_t sb[$];
  ev_t ev;
  int  n_rdy_low = 0;
  int  n_stall_rd = 0;
  bit  rw_clash = 1'b0;

  task automatic push_cell(input int n);
    for (int i = 1; i <= n; i++) sb.push_back('{done: 1'b0, idx: i, data: pat(i)});
    sb.push_back('{done: 1'b1, idx: 0, data: '0});
  endtask

  // Monitor: pops the scoreboard on every beat or done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rden && mem_wren) rw_clash = 1'b1;
      if (wr_valid && !wr_ready) n_rdy_low++;
      if (rd_stall && mem_rden) n_stall_rd++;
      if (rd_valid || rd_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: valid=%0b done=%0b idx=%0d, nothing expected (cycle %0d)",
                   rd_valid, rd_done, rd_idx, cyc);
        end else begin
          ev = sb.pop_front();
          chk("sb_done", 256'(rd_done), 256'(ev.done));
          if (!ev.done) begin
            chk("sb_idx", 256'(rd_idx), 256'(ev.idx));
            chk("sb_data", 256'(rd_data), 256'(ev.data));
          end
        end
      end
    end
  end

  task automatic all_zero(input string name);
    chk({name, "_ctl"}, 256'({rd_busy, rd_valid, rd_done, cnt_err, wr_ready, mem_rden, mem_wren,
                              rd_idx, rd_cnt, mem_address}), 256'(0));
    chk({name, "_data"}, 256'({rd_data, mem_data}), 256'(0));
  endtask

  task automatic load(input logic [DW-1:0] w);
    init_req = 1'b1;
    init_cnt = w;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  task automatic start(output int t0);
    rd_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no rd_done within %0d cycles", name, budget);
    end
    @(posedge clk); #1;
  endtask

  int  t0, t, base, n_acc;
  bit  wr_stop, acc;

  initial begin
    rd_start = 1'b0;
    rd_stall = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    init_req = 1'b0;
    init_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Count 3, no contention.
    load(96'd3);
    push_cell(3);
    start(t0);
    wait_done("c3", 40, t);
    chk("c3_done_lat", 256'(t - t0), 256'(9));
    chk("c3_rd_cnt", 256'(rd_cnt), 256'(3));
    chk("c3_cnt_err", 256'(cnt_err), 256'(0));
    chk("c3_busy_clear", 256'(rd_busy), 256'(0));
    chk("c3_sb_empty", 256'(sb.size()), 256'(0));

    // Count 0: no beats, done six cycles after start.
    load(96'd0);
    push_cell(0);
    start(t0);
    wait_done("c0", 20, t);
    chk("c0_done_lat", 256'(t - t0), 256'(6));
    chk("c0_rd_cnt", 256'(rd_cnt), 256'(0));
    chk("c0_sb_empty", 256'(sb.size()), 256'(0));

    // Count 250 clamps to 219; a second rd_start mid-stream is ignored.
    load(96'd250);
    push_cell(219);
    start(t0);
    repeat (20) @(posedge clk);
    #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("c250_busy_mid", 256'(rd_busy), 256'(1));
    chk("c250_err_mid", 256'(cnt_err), 256'(1));
    wait_done("c250", 400, t);
    chk("c250_done_lat", 256'(t - t0), 256'(225));
    chk("c250_rd_cnt", 256'(rd_cnt), 256'(219));
    chk("c250_cnt_err", 256'(cnt_err), 256'(1));
    chk("c250_sb_empty", 256'(sb.size()), 256'(0));

    // Count 5 under continuous writes (one write hits address 0 mid-stream).
    load(96'd5);
    push_cell(5);
    n_acc = 0;
    wr_stop = 1'b0;
    base = n_rdy_low;
    fork
      begin
        while (!wr_stop) begin
          wr_valid = 1'b1;
          wr_addr  = waddr(n_acc);
          wr_data  = wdata(n_acc);
          @(negedge clk);
          acc = wr_ready;
          @(posedge clk); #1;
          if (acc) n_acc++;
        end
        wr_valid = 1'b0;
      end
      begin
        start(t0);
        wait_done("wr", 100, t);
        wr_stop = 1'b1;
      end
    join
    @(posedge clk); #1;
    chk("wr_done_lat", 256'(t - t0), 256'(35));
    chk("wr_ready_low", 256'(n_rdy_low - base), 256'(6));
    chk("wr_rd_cnt", 256'(rd_cnt), 256'(5));
    chk("wr_accepted", 256'(n_acc >= 30), 256'(1));
    for (int j = 0; j < n_acc; j++) chk("wr_mem", 256'(mem[waddr(j)]), 256'(wdata(j)));
    chk("wr_sb_empty", 256'(sb.size()), 256'(0));

    // Stall for 10 cycles right after idx 2 is issued.
    load(96'd5);
    push_cell(5);
    base = n_stall_rd;
    start(t0);
    repeat (5) @(posedge clk);
    #1;
    rd_stall = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_inflight", 256'(sb.size()), 256'(4));
    rd_stall = 1'b0;
    wait_done("stall", 40, t);
    chk("stall_done_lat", 256'(t - t0), 256'(21));
    chk("stall_no_issue", 256'(n_stall_rd - base), 256'(0));
    chk("stall_sb_empty", 256'(sb.size()), 256'(0));

    // Reset mid-stream, then a normal cell.
    load(96'd5);
    push_cell(5);
    start(t0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_beats_seen", 256'(sb.size()), 256'(5));
    rst_n = 1'b0;
    #1;
    all_zero("rst_mid");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    load(96'd3);
    push_cell(3);
    start(t0);
    wait_done("post_rst", 40, t);
    chk("post_rst_done_lat", 256'(t - t0), 256'(9));
    chk("post_rst_rd_cnt", 256'(rd_cnt), 256'(3));
    chk("post_rst_sb_empty", 256'(sb.size()), 256'(0));

    chk("rw_exclusive", 256'(rw_clash), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
